fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: FETCH cycles without mem_ack before fault; used only when FETCH_TIMEOUT_EN is defined.
REQ-002 clk  input  1  rising-edge clock, sole clock.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  begin sequencing; sampled in IDLE only.
REQ-005 pc  input  16  current program counter from the PC block.
REQ-006 mem_req  output  1  instruction-memory read request.
REQ-007 mem_addr  output  16  read address; combinationally equal to pc at all times.
REQ-008 mem_ack  input  1  read data valid on mem_data this cycle.
REQ-009 mem_data  input  16  instruction word.
REQ-010 ir  output  16  instruction register.
REQ-011 ir_valid  output  1  high for exactly the EXEC cycle.
REQ-012 inc, add, sub  output  1 each  PC update controls, mutually exclusive, one-cycle pulses.
REQ-013 offset  output  16  PC offset, zero-extended ir[11:0].
REQ-014 halted  output  1  high in HALT.
REQ-015 fault  output  1  high in FAULT; constant 0 without FETCH_TIMEOUT_EN.

Function
REQ-016 States IDLE, FETCH, EXEC, HALT, FAULT; FAULT is reachable only with FETCH_TIMEOUT_EN.
REQ-017 IDLE: start=1 -> FETCH next edge; all control outputs 0.
REQ-018 FETCH: mem_req=1; mem_ack=1 -> ir<=mem_data, go to EXEC; otherwise hold.
REQ-019 EXEC lasts one cycle, Moore-decoded from ir; ir[15:12]=4'hC -> add=1; 4'hD -> sub=1; 4'hF -> no pulse, next state HALT; any other value -> inc=1. Next state is FETCH except for 4'hF.
REQ-020 offset = {4'b0, ir[11:0]} in every state; inc/add/sub = 0 outside EXEC.
REQ-021 Latency: mem_ack at cycle N -> EXEC at N+1 -> updated pc and mem_req=1 at N+2; there is no back-to-back request.
REQ-022 HALT: halted=1, mem_req=0, start and mem_ack ignored, exit only by reset.
REQ-023 mem_ack outside FETCH is ignored; ir changes only on an accepted ack.
REQ-024 PC wrap-around (0xFFFF+1, 0x0000-offset) is owned by the PC block; fetch_ctrl forwards pc unchanged.
REQ-025 start asserted outside IDLE has no effect.

Reset
REQ-026 reset=0 at a clock edge: state<=IDLE, ir<=0, timeout counter<=0.
REQ-027 In IDLE after reset, mem_req, ir_valid, inc, add, sub, halted and fault are 0, and offset is 0.
REQ-028 Reset dominates start, mem_ack and timeout expiry in the same cycle; reset mid-FETCH drops mem_req after that edge.

Configuration
REQ-029 With FETCH_TIMEOUT_EN defined:
- a counter clears on entry to FETCH and increments each FETCH cycle without ack;
- when the count reaches TIMEOUT_CYCLES, the next state is FAULT (fault=1, mem_req=0, held until reset);
- an ack in the expiry cycle wins and the FSM goes to EXEC.
REQ-030 Without FETCH_TIMEOUT_EN: no counter logic, FETCH waits indefinitely, fault is tied to 0.

Structure
REQ-031 Package fetch_pkg holds WIDTH=16, opcode constants OP_JF=4'hC, OP_JB=4'hD and OP_HALT=4'hF, and the state enum typedef.
REQ-032 One combinational sub-module instr_decode maps ir to inc, add, sub, offset and is_halt; fetch_ctrl gates its outputs with the EXEC state.

Verification
REQ-033 Reset then start with pc=0x0000, ack after 2 wait cycles with data 0x1234 -> ir=0x1234, one cycle with inc=1 and ir_valid=1, then mem_req=1 again.
REQ-034 Data 0xC005 at pc=0x0010 -> add=1 and offset=0x0005 for one cycle; the next mem_addr is 0x0015.
REQ-035 Data 0xD003 at pc=0x0001 -> sub=1 and offset=0x0003; the next mem_addr is 0xFFFE.
REQ-036 Data 0xF000 -> no inc/add/sub pulse, halted=1 permanently, start and mem_ack ignored, reset returns to IDLE.
REQ-037 FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack -> fault=1 and mem_req=0 after 4 FETCH cycles; a repeat run with ack in the 4th cycle -> EXEC with fault=0.
REQ-038 reset=0 while mem_req=1 -> mem_req=0, ir=0 and state IDLE after that edge; a stray mem_ack in IDLE leaves ir unchanged.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, opcode constants and FSM state encoding for the fetch controller.
package fetch_pkg;

   localparam int WIDTH = 16;

   localparam logic [3:0] OP_JF   = 4'hC;
   localparam logic [3:0] OP_JB   = 4'hD;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_HALT,
      S_FAULT
   } state_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decode of the instruction register into PC update controls.
module instr_decode
   import fetch_pkg::*;
(
   input  logic [WIDTH-1:0] ir,
   output logic             inc,
   output logic             add,
   output logic             sub,
   output logic             is_halt,
   output logic [WIDTH-1:0] offset
);

   // NOTE: every output gets a default before the case, so no latch is inferred.
   always_comb begin
      inc     = 1'b0;
      add     = 1'b0;
      sub     = 1'b0;
      is_halt = 1'b0;
      offset  = WIDTH'(ir[11:0]);
      case (ir[15:12])
         OP_JF:   add     = 1'b1;
         OP_JB:   sub     = 1'b1;
         OP_HALT: is_halt = 1'b1;
         default: inc     = 1'b1;
      endcase
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: IDLE -> FETCH -> EXEC loop, with HALT and optional FAULT.
// Define FETCH_TIMEOUT_EN to enable the FETCH watchdog that moves to FAULT.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] pc,
   output logic             mem_req,
   output logic [WIDTH-1:0] mem_addr,
   input  logic             mem_ack,
   input  logic [WIDTH-1:0] mem_data,
   output logic [WIDTH-1:0] ir,
   output logic             ir_valid,
   output logic             inc,
   output logic             add,
   output logic             sub,
   output logic [WIDTH-1:0] offset,
   output logic             halted,
   output logic             fault
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] ir_q, ir_d;

   logic             dec_inc, dec_add, dec_sub, dec_is_halt;
   logic [WIDTH-1:0] dec_offset;

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expired;

   // Compared one below the limit so FAULT follows exactly TIMEOUT_CYCLES ack-less FETCH cycles.
   assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   instr_decode u_decode (
      .ir      (ir_q),
      .inc     (dec_inc),
      .add     (dec_add),
      .sub     (dec_sub),
      .is_halt (dec_is_halt),
      .offset  (dec_offset)
   );

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
`ifdef FETCH_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         S_FETCH: begin
            if (mem_ack) begin
               ir_d    = mem_data;
               state_d = S_EXEC;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (expired) begin
               state_d = S_FAULT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         S_EXEC: begin
            if (dec_is_halt) begin
               state_d = S_HALT;
            end else begin
               state_d = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         S_HALT:  state_d = S_HALT;
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
`ifdef FETCH_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
`ifdef FETCH_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign mem_addr = pc;
   assign mem_req  = (state_q == S_FETCH);
   assign ir       = ir_q;
   assign ir_valid = (state_q == S_EXEC);
   assign inc      = ir_valid & dec_inc;
   assign add      = ir_valid & dec_add;
   assign sub      = ir_valid & dec_sub;
   assign offset   = dec_offset;
   assign halted   = (state_q == S_HALT);

`ifdef FETCH_TIMEOUT_EN
   assign fault = (state_q == S_FAULT);
`else
   logic timeout_unused;

   assign fault          = 1'b0;
   assign timeout_unused = (TIMEOUT_CYCLES != 0);
`endif

endmodule
